// File: rtl/div_seq_ctrl_pkg.sv
// div_seq_ctrl_pkg -- shared types and constants for the sequential divider.
//   div_state_t : controller state encoding
//   DIV_ITER    : radix-2 iterations per divide
//   DIV_LAT     : start-to-done latency in cycles on the iterative path
//   DIV_ZERO_Q  : quotient produced by an unsigned divide-by-zero
package div_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_BUSY = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } div_state_t;

   localparam int          DIV_ITER   = 32;
   localparam int          DIV_LAT    = 35;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if -- EX-stage <-> divider handshake bundle.
//   master : pipeline side (drives start/divsigned/a/b/annul)
//   slave  : divider side  (drives stall/done/hilowe/hi_i/lo_i)
interface div_seq_ctrl_if;
   logic        start;
   logic        divsigned;
   logic [31:0] a;
   logic [31:0] b;
   logic        annul;
   logic        stall;
   logic        done;
   logic        hilowe;
   logic [31:0] hi_i;
   logic [31:0] lo_i;

   modport master (
      output start, divsigned, a, b, annul,
      input  stall, done, hilowe, hi_i, lo_i
   );

   modport slave (
      input  start, divsigned, a, b, annul,
      output stall, done, hilowe, hi_i, lo_i
   );
endinterface

// File: rtl/div_seq_ctrl_core.sv
// div_core -- unsigned radix-2 restoring shift-subtract datapath.
//   clk, rst   : clock, synchronous active-high reset
//   init       : load dividend/divisor magnitudes, clear partial remainder
//   step       : one restoring iteration, quotient bit shifted in LSB (MSB-first)
//   dividend   : unsigned dividend (loaded on init)
//   divisor    : unsigned divisor (loaded on init)
//   quotient   : quotient after DIV_ITER steps
//   remainder  : remainder after DIV_ITER steps
module div_core (
   input  logic        clk,
   input  logic        rst,
   input  logic        init,
   input  logic        step,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [32:0] rem;
   logic [31:0] quo;
   logic [31:0] dvs;
   logic [33:0] trial;

   // The quotient register doubles as the dividend shifter: its MSB feeds the
   // remainder while the new quotient bit enters at the LSB. One extra bit of
   // headroom gives the borrow that decides restore versus keep.
   assign trial = {rem, quo[31]} - {2'b00, dvs};

   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         quo <= '0;
         dvs <= '0;
      end else if (init) begin
         rem <= '0;
         quo <= dividend;
         dvs <= divisor;
      end else if (step) begin
         if (!trial[33]) rem <= trial[32:0];
         else            rem <= {rem[31:0], quo[31]};
         quo <= {quo[30:0], ~trial[33]};
      end
   end

   assign quotient  = quo;
   assign remainder = rem[31:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl -- multi-cycle DIV/DIVU controller for the EX stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : div_seq_ctrl_if.slave (start/divsigned/a/b/annul in;
//          stall/done/hilowe/hi_i/lo_i out)
// Build option: DIV_ZERO_FAST_EN -- a zero divisor skips the iteration and
// goes straight to DONE with the divide-by-zero results.
//
// state | meaning
// IDLE  | waiting for start; operands latched on accept
// PREP  | operand magnitudes loaded into div_core, iteration counter armed
// BUSY  | one restoring step per cycle, DIV_ITER cycles
// FIX   | signs applied, results registered into hi_i/lo_i
// DONE  | one-cycle done/hilowe strobe, pipeline released
module div_seq_ctrl
   import div_seq_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   div_seq_ctrl_if.slave    bus
);

   localparam logic [4:0] ITER_LAST = 5'(DIV_ITER - 1);

   div_state_t  state, state_nxt;
   logic [31:0] a_q, b_q;
   logic        sgn_q;
   logic [4:0]  cnt;
   logic [31:0] hi_r, lo_r;

   logic        accept, core_init, core_step, fix_we;
   logic        stall_c, done_c;
   logic [31:0] core_q, core_r;
   logic        neg_q, neg_r;
`ifdef DIV_ZERO_FAST_EN
   logic        zero_we;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      core_init = 1'b0;
      core_step = 1'b0;
      fix_we    = 1'b0;
      stall_c   = 1'b0;
      done_c    = 1'b0;
`ifdef DIV_ZERO_FAST_EN
      zero_we   = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (bus.start && !bus.annul) begin
               accept  = 1'b1;
               stall_c = 1'b1;
`ifdef DIV_ZERO_FAST_EN
               if (bus.b == 32'd0) begin
                  zero_we   = 1'b1;
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_PREP;
               end
`else
               state_nxt = ST_PREP;
`endif
            end
         end
         ST_PREP: begin
            stall_c   = 1'b1;
            core_init = !bus.annul;
            state_nxt = bus.annul ? ST_IDLE : ST_BUSY;
         end
         ST_BUSY: begin
            stall_c   = 1'b1;
            core_step = !bus.annul;
            if (bus.annul)         state_nxt = ST_IDLE;
            else if (cnt == 5'd0)  state_nxt = ST_FIX;
         end
         ST_FIX: begin
            stall_c   = 1'b1;
            fix_we    = !bus.annul;
            state_nxt = bus.annul ? ST_IDLE : ST_DONE;
         end
         ST_DONE: begin
            // A flushed instruction must not write HI/LO; a new start here
            // belongs to the next instruction and is taken from IDLE.
            done_c    = !bus.annul;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
      end else if (accept) begin
         a_q   <= bus.a;
         b_q   <= bus.b;
         sgn_q <= bus.divsigned;
      end
   end

   // Down-counter: armed in PREP, BUSY ends on the terminal count.
   always_ff @(posedge clk) begin
      if (rst)                         cnt <= '0;
      else if (core_init)              cnt <= ITER_LAST;
      else if (core_step && cnt != 0)  cnt <= cnt - 5'd1;
   end

   div_core u_core (
      .clk       (clk),
      .rst       (rst),
      .init      (core_init),
      .step      (core_step),
      .dividend  (mag32(a_q, sgn_q)),
      .divisor   (mag32(b_q, sgn_q)),
      .quotient  (core_q),
      .remainder (core_r)
   );

   // A zero divisor yields q=all-ones, r=|a| from the restoring loop; the
   // ordinary sign fix then produces the required divide-by-zero results.
   assign neg_q = sgn_q & (a_q[31] ^ b_q[31]);
   assign neg_r = sgn_q & a_q[31];

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (fix_we) begin
         lo_r <= neg_q ? (32'd0 - core_q) : core_q;
         hi_r <= neg_r ? (32'd0 - core_r) : core_r;
      end
`ifdef DIV_ZERO_FAST_EN
      else if (zero_we) begin
         lo_r <= (bus.divsigned && bus.a[31]) ? 32'd1 : DIV_ZERO_Q;
         hi_r <= bus.a;
      end
`endif
   end

   assign bus.stall  = stall_c;
   assign bus.done   = done_c;
   assign bus.hilowe = done_c;
   assign bus.hi_i   = hi_r;
   assign bus.lo_i   = lo_r;

endmodule
